serial_packet_receiver: RTL and testbench

Parametrised serial packet receiver for the inter-board handshake/data wires. After a start pulse it hunts for a configurable syncword, then shifts in a DATA_BITS-wide payload and an optional even-parity bit. It holds the packet with done and error flags until re-armed. Compared with the fixed handshake receiver, it adds explicit FSM control, parity checking, a sync-hunt timeout and mid-packet restart. It sits between the GPIO input synchroniser and the network protocol FSM.

---
 rtl/serial_packet_receiver.sv | 161 ++++++++++++++++
 tb/tb_serial_packet_receiver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_packet_receiver.sv
// serial_packet_receiver: hunts for a syncword after a start pulse, then shifts in a
// DATA_BITS payload (first bit ends in the MSB) plus an optional even-parity bit.
// Latency: receive_done rises DATA_BITS+PARITY_EN edges after the edge that samples the last sync bit.
// Backpressure: none; one bit per clk. The result is held until receive_start, game_active low or reset.
//
// Ports:
//   clk, rst_l          clock and synchronous active-low reset
//   receive_start       1-cycle pulse: clear results and start hunting (ignored while game_active=0)
//   game_active         low = abort to IDLE, drop receive_done, hold other results
//   serial_in           synchronised serial bit, one per clk
//   data_out            received payload
//   receive_done        packet complete
//   parity_err          parity mismatch on the held packet (meaningful while receive_done=1)
//   timeout             sync hunt expired without a match
//   busy                high in HUNT, RECV and PAR
module serial_packet_receiver #(
   parameter int unsigned           SYNC_BITS      = 8,
   parameter logic [SYNC_BITS-1:0]  SYNCWORD       = 8'hA5,
   parameter int unsigned           DATA_BITS      = 32,
   parameter int unsigned           PARITY_EN      = 1,
   parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic                 receive_start,
   input  logic                 game_active,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 receive_done,
   output logic                 parity_err,
   output logic                 timeout,
   output logic                 busy
);

   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int HW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   // The oldest bit of the sync window is only needed for the compare, never
   // stored, so the history register holds SYNC_BITS-1 bits.
   localparam int SH = (SYNC_BITS > 1) ? SYNC_BITS - 1 : 1;

   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_BITS);
   // With the timeout disabled the hunt counter just saturates at all-ones.
   localparam logic [HW-1:0] HUNT_MAX = (TIMEOUT_CYCLES == 0) ? {HW{1'b1}} : HW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HUNT = 3'd1,
      RECV = 3'd2,
      PAR  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t                 state;
   logic [SH-1:0]          sync_reg;
   logic [BW-1:0]          bit_cnt;
   logic [HW-1:0]          hunt_cnt;
   logic                   par_acc;

   logic [SYNC_BITS-1:0]   sync_shift;
   logic [DATA_BITS-1:0]   data_shift;
   logic                   sync_match;
   logic                   hunt_expire;

   generate
      if (SYNC_BITS > 1) begin : g_sync_wide
         assign sync_shift = {sync_reg, serial_in};
      end else begin : g_sync_one
         assign sync_shift = serial_in;
      end
      if (DATA_BITS > 1) begin : g_data_wide
         assign data_shift = {data_out[DATA_BITS-2:0], serial_in};
      end else begin : g_data_one
         assign data_shift = serial_in;
      end
   endgenerate

   // Compare the window including the bit arriving this cycle, so a match is
   // taken on the edge that samples the last sync bit.
   assign sync_match  = (sync_shift == SYNCWORD);
   // Expiry is flagged on the cycle whose increment would reach the limit.
   assign hunt_expire = (TIMEOUT_CYCLES != 0) && (hunt_cnt == HUNT_MAX - 1'b1);

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state        <= IDLE;
         data_out     <= '0;
         receive_done <= 1'b0;
         parity_err   <= 1'b0;
         timeout      <= 1'b0;
         busy         <= 1'b0;
         sync_reg     <= '0;
         bit_cnt      <= '0;
         hunt_cnt     <= '0;
         par_acc      <= 1'b0;
      end else if (!game_active) begin
         state        <= IDLE;
         busy         <= 1'b0;
         receive_done <= 1'b0;
      end else if (receive_start) begin
         state        <= HUNT;
         busy         <= 1'b1;
         data_out     <= '0;
         receive_done <= 1'b0;
         parity_err   <= 1'b0;
         timeout      <= 1'b0;
         sync_reg     <= '0;
         bit_cnt      <= '0;
         hunt_cnt     <= '0;
         par_acc      <= 1'b0;
      end else begin
         case (state)
            HUNT: begin
               // No clearing on mismatch: overlapping candidates stay in the window.
               sync_reg <= sync_shift[SH-1:0];
               if (hunt_cnt != HUNT_MAX) begin
                  hunt_cnt <= hunt_cnt + 1'b1;
               end
               if (sync_match) begin
                  state <= RECV;
               end else if (hunt_expire) begin
                  timeout <= 1'b1;
                  state   <= IDLE;
                  busy    <= 1'b0;
               end
            end
            RECV: begin
               data_out <= data_shift;
               par_acc  <= par_acc ^ serial_in;
               if (bit_cnt != BIT_MAX) begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
               if (bit_cnt == LAST_BIT) begin
                  if (PARITY_EN != 0) begin
                     state <= PAR;
                  end else begin
                     state        <= DONE;
                     receive_done <= 1'b1;
                     busy         <= 1'b0;
                  end
               end
            end
            PAR: begin
               // Even parity: an odd count of ones over payload+parity is an error.
               parity_err   <= par_acc ^ serial_in;
               receive_done <= 1'b1;
               state        <= DONE;
               busy         <= 1'b0;
            end
            IDLE, DONE: begin
               // Results held; serial_in ignored.
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_packet_receiver.sv
module tb_serial_packet_receiver;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        receive_start;
   logic        game_active;
   logic        serial_in;
   logic [15:0] data_out;
   logic        receive_done;
   logic        parity_err;
   logic        timeout;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   serial_packet_receiver #(
      .SYNC_BITS      (8),
      .SYNCWORD       (8'hA5),
      .DATA_BITS      (16),
      .PARITY_EN      (1),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk           (clk),
      .rst_l         (rst_l),
      .receive_start (receive_start),
      .game_active   (game_active),
      .serial_in     (serial_in),
      .data_out      (data_out),
      .receive_done  (receive_done),
      .parity_err    (parity_err),
      .timeout       (timeout),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      serial_in = b;
      tick();
   endtask

   // Sends the low n bits of v, MSB first.
   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         send_bit(v[i]);
      end
   endtask

   task automatic pulse_start();
      receive_start = 1'b1;
      tick();
      receive_start = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_l         = 1'b0;
      receive_start = 1'b0;
      game_active   = 1'b1;
      serial_in     = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_data",    32'(data_out),     32'h0);
      chk("rst_done",    32'(receive_done), 32'h0);
      chk("rst_perr",    32'(parity_err),   32'h0);
      chk("rst_timeout", 32'(timeout),      32'h0);
      chk("rst_busy",    32'(busy),         32'h0);
      rst_l = 1'b1;
      tick();

      // Nominal packet: 0,0,0, A5, BEEF (13 ones), parity 1 -> even
      pulse_start();
      chk("nom_busy_start", 32'(busy), 32'h1);
      send_bits(32'h0, 3);
      send_bits(32'hA5, 8);
      chk("nom_busy_sync", 32'(busy), 32'h1);
      send_bits(32'hBEEF, 16);
      chk("nom_done_t16", 32'(receive_done), 32'h0);
      chk("nom_busy_t16", 32'(busy),         32'h1);
      send_bit(1'b1);
      chk("nom_done_t17", 32'(receive_done), 32'h1);
      chk("nom_data",     32'(data_out),     32'h0000BEEF);
      chk("nom_perr",     32'(parity_err),   32'h0);
      chk("nom_busy",     32'(busy),         32'h0);
      send_bits(32'h5A5A, 16);
      chk("nom_hold_data", 32'(data_out),     32'h0000BEEF);
      chk("nom_hold_done", 32'(receive_done), 32'h1);

      // Parity error: same packet, parity bit 0
      pulse_start();
      chk("par_clear_done", 32'(receive_done), 32'h0);
      chk("par_clear_data", 32'(data_out),     32'h0);
      send_bits(32'h0, 3);
      send_bits(32'hA5, 8);
      send_bits(32'hBEEF, 16);
      send_bit(1'b0);
      chk("par_done", 32'(receive_done), 32'h1);
      chk("par_data", 32'(data_out),     32'h0000BEEF);
      chk("par_perr", 32'(parity_err),   32'h1);

      // Overlapping sync: 101001 then A5, payload 0001, parity 1
      pulse_start();
      chk("ovl_perr_clear", 32'(parity_err), 32'h0);
      send_bits(32'b101001, 6);
      send_bits(32'hA5, 8);
      send_bits(32'h0001, 16);
      chk("ovl_done_early", 32'(receive_done), 32'h0);
      send_bit(1'b1);
      chk("ovl_done", 32'(receive_done), 32'h1);
      chk("ovl_data", 32'(data_out),     32'h00000001);
      chk("ovl_perr", 32'(parity_err),   32'h0);

      // Timeout: 64 HUNT cycles of zeros
      pulse_start();
      serial_in = 1'b0;
      for (int i = 0; i < 63; i++) tick();
      chk("to_before",      32'(timeout), 32'h0);
      chk("to_busy_before", 32'(busy),    32'h1);
      tick();
      chk("to_flag", 32'(timeout),      32'h1);
      chk("to_busy", 32'(busy),         32'h0);
      chk("to_done", 32'(receive_done), 32'h0);
      tick();
      chk("to_hold", 32'(timeout), 32'h1);
      pulse_start();
      chk("to_cleared", 32'(timeout), 32'h0);
      chk("to_rehunt",  32'(busy),    32'h1);

      // Restart mid-payload after 8 bits, then a full 1234 packet
      send_bits(32'hA5, 8);
      send_bits(32'hFF, 8);
      chk("rs_partial", 32'(data_out), 32'h000000FF);
      pulse_start();
      chk("rs_data",  32'(data_out),  32'h0);
      chk("rs_state", 32'(dut.state), 32'h1);
      chk("rs_busy",  32'(busy),      32'h1);
      send_bits(32'hA5, 8);
      send_bits(32'h1234, 16);
      send_bit(1'b1);
      chk("rs_done", 32'(receive_done), 32'h1);
      chk("rs_pkt",  32'(data_out),     32'h00001234);
      chk("rs_perr", 32'(parity_err),   32'h0);

      // Abort from DONE with game_active low; start ignored while low
      game_active = 1'b0;
      tick();
      chk("ga_done",  32'(receive_done), 32'h0);
      chk("ga_data",  32'(data_out),     32'h00001234);
      chk("ga_state", 32'(dut.state),    32'h0);
      pulse_start();
      chk("ga_start_ignored", 32'(busy),     32'h0);
      chk("ga_data_held",     32'(data_out), 32'h00001234);
      game_active = 1'b1;
      tick();

      // Synchronous reset while in RECV after 4 payload bits (1010)
      pulse_start();
      send_bits(32'hA5, 8);
      send_bits(32'b1010, 4);
      rst_l = 1'b0;
      #3;
      chk("sr_between_data", 32'(data_out), 32'h0000000A);
      chk("sr_between_busy", 32'(busy),     32'h1);
      tick();
      rst_l = 1'b1;
      chk("sr_data",    32'(data_out),     32'h0);
      chk("sr_busy",    32'(busy),         32'h0);
      chk("sr_done",    32'(receive_done), 32'h0);
      chk("sr_perr",    32'(parity_err),   32'h0);
      chk("sr_timeout", 32'(timeout),      32'h0);
      chk("sr_state",   32'(dut.state),    32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
